// File: rtl/quad_decoder_pkg.sv
// Shared types and constants for the quadrature decoder tile.
package quad_decoder_pkg;

    localparam int unsigned COUNT_W    = 8;
    localparam int unsigned FILT_CNT_W = 4;

    localparam int unsigned UI_A_BIT       = 0;
    localparam int unsigned UI_B_BIT       = 1;
    localparam int unsigned UI_LOAD_BIT    = 2;
    localparam int unsigned UI_ERR_CLR_BIT = 3;
    localparam int unsigned UI_DIR_INV_BIT = 4;

    localparam int unsigned UIO_DIR_BIT   = 0;
    localparam int unsigned UIO_STEP_BIT  = 1;
    localparam int unsigned UIO_ERR_BIT   = 2;
    localparam int unsigned UIO_VALID_BIT = 3;

    localparam logic [7:0] UIO_OE_VALUE = 8'h0F;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_TRACK = 1'b1
    } dec_state_t;

endpackage

// File: rtl/quad_input_filter.sv
// Two-flop synchronizer followed by a persistence filter for one encoder phase.
module quad_input_filter
    import quad_decoder_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic filt,
    output logic stable_c
);

    logic                  s1;
    logic                  s2;
    logic [FILT_CNT_W-1:0] cnt;

    // filt only follows s2 once it has disagreed for FILTER_CYCLES consecutive cycles
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1   <= 1'b0;
            s2   <= 1'b0;
            filt <= 1'b0;
            cnt  <= '0;
        end else begin
            s1 <= din;
            s2 <= s1;
            if (s2 == filt) begin
                cnt <= '0;
            end else if (cnt == FILT_CNT_W'(FILTER_CYCLES - 1)) begin
                filt <= s2;
                cnt  <= '0;
            end else begin
                cnt <= cnt + FILT_CNT_W'(1);
            end
        end
    end

    assign stable_c = (s2 == filt);

endmodule

// File: rtl/tt_um_ulriktj_quadrature_decoder.sv
// Quadrature A/B decoder: filtered x4 Gray decode into an 8-bit wrapping position count.
module tt_um_ulriktj_quadrature_decoder
    import quad_decoder_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic filt_a, filt_b, stable_a, stable_b;

    quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_a (
        .clk(clk), .rst_n(rst_n), .din(ui_in[UI_A_BIT]), .filt(filt_a), .stable_c(stable_a)
    );

    quad_input_filter #(.FILTER_CYCLES(FILTER_CYCLES)) u_filt_b (
        .clk(clk), .rst_n(rst_n), .din(ui_in[UI_B_BIT]), .filt(filt_b), .stable_c(stable_b)
    );

    dec_state_t            state_q, state_d;
    logic [1:0]            prev_q, prev_d;
    logic [FILT_CNT_W-1:0] stable_q, stable_d;
    logic [COUNT_W-1:0]    count_q, count_d;
    logic                  dir_q, dir_d;
    logic                  step_q, step_d;
    logic                  err_q, err_d;
    logic                  valid_q, valid_d;

    logic [1:0] cur;
    logic       mv_fwd, mv_rev, mv_bad, mv_up;
    logic       unused_ok;

    assign cur       = {filt_a, filt_b};
    assign unused_ok = &{1'b0, ui_in[7:5], uio_in[3:0]};

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_INIT;
            prev_q   <= 2'b00;
            stable_q <= '0;
            count_q  <= '0;
            dir_q    <= 1'b0;
            step_q   <= 1'b0;
            err_q    <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            stable_q <= stable_d;
            count_q  <= count_d;
            dir_q    <= dir_d;
            step_q   <= step_d;
            err_q    <= err_d;
            valid_q  <= valid_d;
        end
    end

    // Gray transition classification on {prev, cur}, each as {A,B}
    always_comb begin
        mv_fwd = 1'b0;
        mv_rev = 1'b0;
        mv_bad = 1'b0;
        case ({prev_q, cur})
            4'b0010, 4'b1011, 4'b1101, 4'b0100: mv_fwd = 1'b1;
            4'b0001, 4'b0111, 4'b1110, 4'b1000: mv_rev = 1'b1;
            4'b0011, 4'b1100, 4'b1001, 4'b0110: mv_bad = 1'b1;
            default: ;
        endcase
        mv_up = mv_fwd ^ ui_in[UI_DIR_INV_BIT];
    end

    always_comb begin
        state_d  = state_q;
        prev_d   = cur;
        stable_d = '0;
        count_d  = count_q;
        dir_d    = dir_q;
        step_d   = 1'b0;
        err_d    = err_q;

        if (ui_in[UI_ERR_CLR_BIT]) begin
            err_d = 1'b0;
        end

        case (state_q)
            ST_INIT: begin
                // the first filter update after reset is absorbed into prev, never decoded
                if (stable_a && stable_b) begin
                    if (stable_q == FILT_CNT_W'(FILTER_CYCLES - 1)) begin
                        state_d = ST_TRACK;
                    end else begin
                        stable_d = stable_q + FILT_CNT_W'(1);
                    end
                end
                if (cur != prev_q) begin
                    state_d  = ST_TRACK;
                    stable_d = '0;
                end
            end
            ST_TRACK: begin
                if (mv_fwd || mv_rev) begin
                    dir_d   = mv_up;
                    step_d  = 1'b1;
                    count_d = mv_up ? count_q + COUNT_W'(1) : count_q - COUNT_W'(1);
                end
                if (mv_bad) begin
                    err_d = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (ui_in[UI_LOAD_BIT]) begin
            count_d = COUNT_W'(uio_in[7:4]);
            step_d  = 1'b0;
        end

        valid_d = (state_d == ST_TRACK);
    end

    assign uo_out = count_q;
    assign uio_oe = UIO_OE_VALUE;

    always_comb begin
        uio_out                = '0;
        uio_out[UIO_DIR_BIT]   = dir_q;
        uio_out[UIO_STEP_BIT]  = step_q;
        uio_out[UIO_ERR_BIT]   = err_q;
        uio_out[UIO_VALID_BIT] = valid_q;
    end

endmodule

// File: doc/tt_um_ulriktj_quadrature_decoder.md
# tt_um_UlrikTJ_quadrature_decoder

Quadrature (A/B) incremental-encoder decoder for the TinyTapeout tile, the read side of the up/down counter interface: instead of taking explicit enable/up-down controls, it recovers step and direction from two phase-shifted encoder signals. The block synchronizes and glitch-filters A and B, decodes x4 Gray transitions, keeps an 8-bit wrapping position count, and flags illegal transitions. All pins use the standard tile wrapper.

## Interface
- FILTER_CYCLES, 3: consecutive cycles a synchronized input must differ from its filtered value before the filtered value updates (1..15).
- COUNT_W, 8: position counter width; fixed at 8 for the tile pinout.
- clk  in  1  tile clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous and active-low.
- ui_in  in  8  [0]=A, [1]=B, [2]=load, [3]=err_clr, [4]=dir_invert, [7:5] unused.
- uo_out  out  8  position count.
- uio_in  in  8  [7:4]=load value nibble; [3:0] ignored.
- uio_out  out  8  [0]=dir, [1]=step, [2]=err, [3]=valid, [7:4]=0.
- uio_oe  out  8  constant 8'h0F.

## Operation
- Synchronizer: A and B each pass a 2-FF synchronizer (s1, s2); no logic reads raw pins.
- Filter per channel: counter increments each cycle s2 != filt; resets to 0 when s2 == filt; on the cycle the counter would reach FILTER_CYCLES, filt <= s2 and counter <= 0.
- State machine (decoder):
  - INIT (reset state): valid=0; no steps counted. When both channel filters have been stable (s2 == filt) for FILTER_CYCLES cycles, or after first filt update, prev <= {filtA,filtB}; go TRACK. Filters reset with filt = 0; first filter update after reset is absorbed here, never counted.
  - TRACK: valid=1. Each cycle compare cur={filtA,filtB} to prev; prev <= cur.
- Decode in TRACK ({A,B}): up sequence 00->10->11->01->00; down is the reverse. cur==prev: no action. Two-bit change (00<->11, 10<->01): err set, no count, dir unchanged.
- dir_invert=1 swaps up/down meaning for both count and dir.
- Count: up = +1 mod 256 (255->0), down = -1 mod 256 (0->255).
- step: one-cycle pulse coincident with each count change from decode; dir holds last legal direction (1=up), reset 0.
- load=1: count <= {4'b0, uio_in[7:4]}; load has priority over a same-cycle step (step pulse suppressed, prev still updates).
- err sticky; cleared by err_clr=1; same-cycle set and clear: set wins.
- Reset values: count=0, dir=0, step=0, err=0, valid=0, filters/sync=0, state INIT.

## Timing
- Pin change sampled at edge 0: s2 valid after edge 1; filt updates at edge 1+FILTER_CYCLES; count/step/dir update at edge 2+FILTER_CYCLES (5 cycles with default).
- Pulses shorter than FILTER_CYCLES cycles after synchronization are rejected with no output effect.
- Maximum legal edge rate: one filtered transition per FILTER_CYCLES+1 cycles per channel.
- load and err_clr act on the next edge after they are sampled high (through no synchronizer; treated as synchronous controls).
- rst_n low at any edge, including mid-transition: all state returns to reset values on that edge; decoding restarts in INIT.

## Structure
- Package quad_decoder_pkg: state enum {ST_INIT, ST_TRACK}, COUNT_W, uio bit-index constants, UIO_OE_VALUE=8'h0F.
- Sub-module quad_input_filter (synchronizer + glitch filter, parameter FILTER_CYCLES), instantiated twice (A, B); decoder, counter and state machine in the top.

## Test plan
- Reset with A=B=1 held: after settling valid=1, count=0, err=0, step never pulses.
- Four up steps 00->10->11->01->00, each held 8 cycles: count 0->4, four step pulses, dir=1; each update 5 cycles after pin change.
- From count=0, one down step (00->01): count=255, dir=0; repeat with dir_invert=1: count returns to 0, dir=1.
- 2-cycle glitch on A while B stable: no step, count unchanged, err=0.
- Jump 00->11 (both change same cycle): err=1, count unchanged; err_clr pulse -> err=0; err_clr coincident with another illegal jump -> err stays 1.
- load with uio_in[7:4]=4'hA coincident with a decoded up step: count=8'h0A, no step pulse; next up step -> 8'h0B.
